hazard_unit: RTL and testbench

- Feedback side of the 5-stage MIPS pipeline. The control path pushes RegWrite/MemtoReg/MemWrite/Branch down D->E->M->W; this block consumes them with the register numbers and drives stall, flush and forward selects back up the pipe.
- Owns a sequential data-memory wait FSM (MemReqM/MemReady handshake with timeout), so variable-latency memory freezes the pipe cleanly.

---
 rtl/hazard_unit_pkg.sv | 22 ++
 rtl/hazard_unit_mem_wait_fsm.sv | 55 +++++
 rtl/hazard_unit.sv | 126 ++++++++++++
 tb/tb_hazard_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard unit.
package hazard_unit_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_e;

  // $0 is hardwired, so a zero source register can never depend on a writer.
  function automatic logic reg_hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_unit_mem_wait_fsm.sv
// Data-memory wait tracker: freezes the pipe while an M-stage access is
// outstanding and aborts it with a sticky error after MEM_TIMEOUT cycles.
module hazard_unit_mem_wait_fsm
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_access,
  input  logic mem_ready,
  output logic mem_stall,
  output logic abort_cycle,
  output logic mem_err
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  mem_state_e        state;
  logic [WCNT_W-1:0] wcnt;

  // MemReady wins over the timeout in the final wait cycle.
  assign abort_cycle = (state == MEM_WAIT) && !mem_ready && (wcnt == WCNT_LAST);
  assign mem_stall   = mem_access && !mem_ready && !abort_cycle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MEM_IDLE;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (mem_access && !mem_ready) begin
            state <= MEM_WAIT;
            wcnt  <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= MEM_IDLE;
          end else if (abort_cycle) begin
            state   <= MEM_IDLE;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/memory stalls.
// Define HAZARD_PERF_CNT_EN to add saturating stall counters (CNT_W bits).
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             MemReady,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemReqM,
  output logic             MemErr
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] LoadStallCnt
  , output logic [CNT_W-1:0] BranchStallCnt
  , output logic [CNT_W-1:0] MemStallCnt
`endif
);

  logic mem_access;
  logic mem_stall;
  logic abort_cycle;
  logic lw_stall;
  logic branch_stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] dst_m, input logic wr_m,
                                         input logic [REG_W-1:0] dst_w, input logic wr_w);
    if (wr_m && reg_hit(src, dst_m)) return FWD_MEM;
    if (wr_w && reg_hit(src, dst_w)) return FWD_WB;
    return FWD_NONE;
  endfunction

  hazard_unit_mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .mem_access (mem_access),
    .mem_ready  (MemReady),
    .mem_stall  (mem_stall),
    .abort_cycle(abort_cycle),
    .mem_err    (MemErr)
  );

  assign mem_access = MemtoRegM | MemWriteM;
  assign MemReqM    = mem_access & ~abort_cycle;

  assign ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  assign ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  assign ForwardAD = RegWriteM & reg_hit(RsD, WriteRegM);
  assign ForwardBD = RegWriteM & reg_hit(RtD, WriteRegM);

  assign lw_stall = MemtoRegE & (reg_hit(RsD, RtE) | reg_hit(RtD, RtE));
  assign branch_stall = BranchD &
      ((RegWriteE & (reg_hit(RsD, WriteRegE) | reg_hit(RtD, WriteRegE))) |
       (MemtoRegM & (reg_hit(RsD, WriteRegM) | reg_hit(RtD, WriteRegM))));

  // A memory freeze holds E in place, so no bubble is injected there.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (lw_stall || branch_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LoadStallCnt   <= '0;
      BranchStallCnt <= '0;
      MemStallCnt    <= '0;
    end else begin
      if (lw_stall && !mem_stall && (LoadStallCnt != CNT_MAX))
        LoadStallCnt <= LoadStallCnt + CNT_W'(1);
      if (branch_stall && !lw_stall && !mem_stall && (BranchStallCnt != CNT_MAX))
        BranchStallCnt <= BranchStallCnt + CNT_W'(1);
      if (mem_stall && (MemStallCnt != CNT_MAX))
        MemStallCnt <= MemStallCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed hazard scenarios, then randomized traffic
// compared each cycle against a behavioural model of the hazard rules.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  localparam int unsigned MT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM, BranchD, MemReady;
  logic       StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD, MemReqM, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] LoadStallCnt, BranchStallCnt, MemStallCnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model: stall cycles already spent by the current access, sticky error, counters.
  int   m_stalls = 0;
  logic m_err    = 1'b0;
  int   m_ld = 0, m_br = 0, m_ms = 0;
  logic e_abort, e_mstall, e_lw, e_br;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .MemReady(MemReady),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemReqM(MemReqM), .MemErr(MemErr)
`ifdef HAZARD_PERF_CNT_EN
    , .LoadStallCnt(LoadStallCnt), .BranchStallCnt(BranchStallCnt), .MemStallCnt(MemStallCnt)
`endif
  );

  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] src);
    if (RegWriteM && hit(src, WriteRegM)) return 2'd2;
    if (RegWriteW && hit(src, WriteRegW)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    BranchD = 1'b0; MemReady = 1'b0;
  endtask

  task automatic rand_regs();
    RsD = 5'($urandom_range(0, 7)); RtD = 5'($urandom_range(0, 7));
    RsE = 5'($urandom_range(0, 7)); RtE = 5'($urandom_range(0, 7));
    WriteRegE = 5'($urandom_range(0, 7)); WriteRegM = 5'($urandom_range(0, 7));
    WriteRegW = 5'($urandom_range(0, 7));
    RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
    BranchD = 1'($urandom_range(0, 1));
  endtask

  // Settle, derive every expected output from the hazard rules, compare all of them.
  task automatic check_all(input string tag);
    logic acc, hz;
    #2;
    acc      = MemtoRegM | MemWriteM;
    e_abort  = acc && !MemReady && (m_stalls == MT);
    e_mstall = acc && !MemReady && !e_abort;
    e_lw     = MemtoRegE && (hit(RsD, RtE) || hit(RtD, RtE));
    e_br     = BranchD && ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                           (MemtoRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
    hz = e_lw || e_br;
    chk({tag, ".StallF"}, StallF, e_mstall || hz);
    chk({tag, ".StallD"}, StallD, e_mstall || hz);
    chk({tag, ".StallE"}, StallE, e_mstall);
    chk({tag, ".StallM"}, StallM, e_mstall);
    chk({tag, ".FlushE"}, FlushE, !e_mstall && hz);
    chk({tag, ".FlushW"}, FlushW, e_mstall);
    chk({tag, ".ForwardAE"}, ForwardAE, fwd(RsE));
    chk({tag, ".ForwardBE"}, ForwardBE, fwd(RtE));
    chk({tag, ".ForwardAD"}, ForwardAD, RegWriteM && hit(RsD, WriteRegM));
    chk({tag, ".ForwardBD"}, ForwardBD, RegWriteM && hit(RtD, WriteRegM));
    chk({tag, ".MemReqM"}, MemReqM, acc && !e_abort);
    chk({tag, ".MemErr"}, MemErr, m_err);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".LoadStallCnt"}, LoadStallCnt, 16'(m_ld));
    chk({tag, ".BranchStallCnt"}, BranchStallCnt, 16'(m_br));
    chk({tag, ".MemStallCnt"}, MemStallCnt, 16'(m_ms));
`endif
  endtask

  task automatic advance();
    if (e_abort) begin
      m_err    = 1'b1;
      m_stalls = 0;
    end else if (e_mstall) begin
      m_stalls++;
    end else begin
      m_stalls = 0;
    end
    if (e_lw && !e_mstall) m_ld++;
    if (e_br && !e_lw && !e_mstall) m_br++;
    if (e_mstall) m_ms++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int req_cnt;
    int lat, last;
    logic is_ld;

    // Reset with all inputs low: every output is 0.
    clear_inputs();
    reset = 1'b1;
    #16;
    check_all("reset");
    reset = 1'b0;
    check_all("post_reset");
    advance();

    // Forwarding priority and $0 exclusion.
    clear_inputs();
    RsE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b1; WriteRegW = 5'd3; RegWriteW = 1'b1;
    check_all("fwd_mem");
    chk("fwd_mem.AE", ForwardAE, 2'b10);
    RegWriteM = 1'b0;
    check_all("fwd_wb");
    chk("fwd_wb.AE", ForwardAE, 2'b01);
    RsE = 5'd0; RegWriteM = 1'b1; WriteRegM = 5'd0; WriteRegW = 5'd0;
    check_all("fwd_zero");
    chk("fwd_zero.AE", ForwardAE, 2'b00);
    advance();

    // Load-use: one bubble, then the load sits in M.
    clear_inputs();
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; MemReady = 1'b1;
    check_all("lw0");
    chk("lw0.StallF", StallF, 1'b1);
    chk("lw0.FlushE", FlushE, 1'b1);
    chk("lw0.StallE", StallE, 1'b0);
    advance();
    MemtoRegE = 1'b0; RtE = 5'd0; MemtoRegM = 1'b1; WriteRegM = 5'd5; RegWriteM = 1'b1;
    check_all("lw1");
    chk("lw1.StallF", StallF, 1'b0);
    chk("lw1.ForwardAD", ForwardAD, 1'b1);
    advance();

    // Branch depending on an ALU result in E, then forwarded from M.
    clear_inputs();
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd7; RtD = 5'd7;
    check_all("br0");
    chk("br0.StallD", StallD, 1'b1);
    chk("br0.FlushE", FlushE, 1'b1);
    advance();
    RegWriteE = 1'b0; WriteRegE = 5'd0; RegWriteM = 1'b1; WriteRegM = 5'd7;
    check_all("br1");
    chk("br1.ForwardBD", ForwardBD, 1'b1);
    chk("br1.StallF", StallF, 1'b0);
    advance();

    // Memory wait: three stalled cycles, completion on the fourth.
    clear_inputs();
    MemtoRegM = 1'b1; WriteRegM = 5'd9;
    req_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      MemReady = (k == 3);
      check_all("mw");
      if (k < 3) begin
        chk("mw.StallM", StallM, 1'b1);
        chk("mw.FlushW", FlushW, 1'b1);
        chk("mw.FlushE", FlushE, 1'b0);
      end
      req_cnt += int'(MemReqM);
      advance();
    end
    chk("mw.req_cycles", 16'(req_cnt), 16'd4);
    clear_inputs();
    check_all("mw_done");
    chk("mw_done.idle", dut.u_fsm.state == MEM_IDLE, 1'b1);
    advance();

    // Timeout: four stall cycles, then an abort cycle and a sticky error.
    clear_inputs();
    MemWriteM = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_all("to");
      chk("to.StallM", StallM, 1'b1);
      advance();
    end
    check_all("to_abort");
    chk("to_abort.StallM", StallM, 1'b0);
    chk("to_abort.MemReqM", MemReqM, 1'b0);
    advance();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      check_all("to_sticky");
      chk("to_sticky.MemErr", MemErr, 1'b1);
      advance();
    end

    // Asynchronous reset in the middle of a wait.
    clear_inputs();
    MemWriteM = 1'b1;
    check_all("rw0");
    advance();
    check_all("rw1");
    chk("rw1.in_wait", dut.u_fsm.state == MEM_WAIT, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst.MemErr", MemErr, 1'b0);
    chk("async_rst.idle", dut.u_fsm.state == MEM_IDLE, 1'b1);
    m_err = 1'b0; m_stalls = 0; m_ld = 0; m_br = 0; m_ms = 0;
    clear_inputs();
    check_all("rst_hold");
    advance();
    reset = 1'b0;
    check_all("rst_rel");
    advance();

    // Load-use coinciding with a memory stall: freeze first, then one bubble.
    clear_inputs();
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; MemtoRegM = 1'b1; WriteRegM = 5'd2;
    check_all("both0");
    chk("both0.FlushE", FlushE, 1'b0);
    chk("both0.StallE", StallE, 1'b1);
    advance();
    MemReady = 1'b1;
    check_all("both1");
    chk("both1.FlushE", FlushE, 1'b1);
    chk("both1.StallE", StallE, 1'b0);
    advance();
    clear_inputs();
    check_all("both2");
`ifdef HAZARD_PERF_CNT_EN
    chk("both2.MemStallCnt", MemStallCnt, 16'd1);
    chk("both2.LoadStallCnt", LoadStallCnt, 16'd1);
`endif
    advance();

    // Randomized traffic: legal memory transactions of random latency.
    for (int t = 0; t < 50; t++) begin
      lat   = int'($urandom_range(0, MT + 2));
      last  = (lat > MT) ? MT : lat;
      is_ld = 1'($urandom_range(0, 1));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        rand_regs();
        MemtoRegM = 1'b0; MemWriteM = 1'b0;
        MemReady = 1'($urandom_range(0, 1));
        check_all("rnd_gap");
        advance();
      end
      for (int k = 0; k <= last; k++) begin
        rand_regs();
        MemtoRegM = is_ld; MemWriteM = !is_ld;
        MemReady = (k == lat);
        check_all("rnd_mem");
        advance();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
